in_service_controller: RTL

Sequences the interrupt acknowledge cycle of the 8259-compatible PIC.
- Takes the one-hot winning request from the priority resolver.
- Drives INT to the CPU and runs the INTA pulse sequence (8086 two-pulse or MCS-80 three-pulse).
- Owns the in-service register and the priority rotation value, and applies EOI and rotation commands.
- Its `in_service_register` and `priority_rotate` outputs feed back into the priority resolver.

---
 rtl/in_service_controller_pkg.sv | 53 +++++
 rtl/in_service_controller_eoi_level_select.sv | 21 ++
 rtl/in_service_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/in_service_controller_pkg.sv
// Shared types, state encoding and bit-vector helpers for the 8259-style in-service controller.
package in_service_controller_pkg;

    localparam int unsigned NUM_LEVELS = 8;
    localparam int unsigned LEVEL_W    = 3;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACK1 = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACK2 = 2'd2;
    localparam logic [STATE_W-1:0] ST_ACK3 = 2'd3;

    localparam logic [7:0] MCS80_CALL_OPCODE = 8'hCD;

    function automatic logic [NUM_LEVELS-1:0] rotate_right(
        input logic [NUM_LEVELS-1:0] source,
        input logic [LEVEL_W-1:0]    rotate
    );
        logic [2*NUM_LEVELS-1:0] doubled;
        doubled = {source, source} >> rotate;
        return doubled[NUM_LEVELS-1:0];
    endfunction

    function automatic logic [NUM_LEVELS-1:0] rotate_left(
        input logic [NUM_LEVELS-1:0] source,
        input logic [LEVEL_W-1:0]    rotate
    );
        logic [2*NUM_LEVELS-1:0] doubled;
        doubled = {source, source} << rotate;
        return doubled[2*NUM_LEVELS-1:NUM_LEVELS];
    endfunction

    // Isolates the lowest set bit, i.e. the highest-priority request in unrotated order.
    function automatic logic [NUM_LEVELS-1:0] resolv_priority(
        input logic [NUM_LEVELS-1:0] request
    );
        return request & (~request + NUM_LEVELS'(1));
    endfunction

    function automatic logic [LEVEL_W-1:0] encode_8to3(
        input logic [NUM_LEVELS-1:0] one_hot
    );
        logic [LEVEL_W-1:0] level;
        level = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (one_hot[i]) begin
                level = LEVEL_W'(i);
            end
        end
        return level;
    endfunction

endpackage

// File: rtl/in_service_controller_eoi_level_select.sv
// Picks the in-service level a non-specific EOI clears: highest priority relative to priority_rotate.
module in_service_controller_eoi_level_select
    import in_service_controller_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] in_service_register,
    input  logic [LEVEL_W-1:0]    priority_rotate,
    output logic [LEVEL_W-1:0]    eoi_level_c,
    output logic                  eoi_valid_c
);

    logic [NUM_LEVELS-1:0] rotated_c;
    logic [NUM_LEVELS-1:0] winner_c;

    always_comb begin
        rotated_c   = rotate_right(in_service_register, priority_rotate);
        winner_c    = rotate_left(resolv_priority(rotated_c), priority_rotate);
        eoi_level_c = encode_8to3(winner_c);
        eoi_valid_c = |in_service_register;
    end

endmodule

// File: rtl/in_service_controller.sv
// Interrupt acknowledge sequencer: INT pin, INTA byte sequence, in-service register and priority rotation.
module in_service_controller
    import in_service_controller_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  interrupt_acknowledge_n,
    input  logic [NUM_LEVELS-1:0] interrupt,
    input  logic                  u8086_or_mcs80_config,
    input  logic                  auto_eoi_config,
    input  logic                  auto_rotate_mode,
    input  logic [4:0]            interrupt_vector_address,
    input  logic [7:0]            call_address_high,
    input  logic                  eoi_command,
    input  logic                  eoi_specific,
    input  logic [LEVEL_W-1:0]    eoi_level,
    input  logic                  eoi_rotate,
    input  logic                  set_priority_command,
    input  logic [LEVEL_W-1:0]    set_priority_level,
    output logic                  interrupt_to_cpu,
    output logic [NUM_LEVELS-1:0] in_service_register,
    output logic [LEVEL_W-1:0]    priority_rotate,
    output logic [NUM_LEVELS-1:0] clear_interrupt_request,
    output logic [7:0]            data_bus_out,
    output logic                  out_data_enable
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic                  inta_prev_q, inta_prev_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic [NUM_LEVELS-1:0] isr_q, isr_d;
    logic [LEVEL_W-1:0]    rot_q, rot_d;
    logic [NUM_LEVELS-1:0] cir_q, cir_d;
    logic                  int_q, int_d;
    logic [7:0]            data_q, data_d;
    logic                  ode_q, ode_d;

    logic                  inta_fall_c;
    logic                  inta_rise_c;
    logic                  seq_done_c;
    logic [LEVEL_W-1:0]    ack_level_c;
    logic [NUM_LEVELS-1:0] isr_set_c;
    logic [NUM_LEVELS-1:0] isr_clr_c;
    logic [LEVEL_W-1:0]    ns_eoi_level_c;
    logic                  ns_eoi_valid_c;

    in_service_controller_eoi_level_select u_eoi_level_select (
        .in_service_register (isr_q),
        .priority_rotate     (rot_q),
        .eoi_level_c         (ns_eoi_level_c),
        .eoi_valid_c         (ns_eoi_valid_c)
    );

    assign inta_fall_c = inta_prev_q & ~interrupt_acknowledge_n;
    assign inta_rise_c = ~inta_prev_q & interrupt_acknowledge_n;
    // The rising edge that ends the sequence: ACK2 for 8086, ACK3 for MCS-80.
    assign seq_done_c  = inta_rise_c &
                         (((state_q == ST_ACK2) & u8086_or_mcs80_config) | (state_q == ST_ACK3));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (inta_fall_c) state_d = ST_ACK1;
            ST_ACK1: if (inta_fall_c) state_d = ST_ACK2;
            ST_ACK2: begin
                if (u8086_or_mcs80_config) begin
                    if (inta_rise_c) state_d = ST_IDLE;
                end else if (inta_fall_c) begin
                    state_d = ST_ACK3;
                end
            end
            ST_ACK3: if (inta_rise_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inta_prev_d = interrupt_acknowledge_n;
        level_d     = level_q;
        rot_d       = rot_q;
        cir_d       = '0;
        int_d       = 1'b0;
        data_d      = '0;
        ode_d       = 1'b0;
        isr_set_c   = '0;
        isr_clr_c   = '0;
        ack_level_c = (interrupt == '0) ? LEVEL_W'(7) : encode_8to3(interrupt);

        if (state_q == ST_IDLE) begin
            if (inta_fall_c) begin
                level_d = ack_level_c;
                if (interrupt != '0) begin
                    isr_set_c = NUM_LEVELS'(1) << ack_level_c;
                    cir_d     = NUM_LEVELS'(1) << ack_level_c;
                end
            end else begin
                int_d = |interrupt;
            end
        end

        if (seq_done_c && auto_eoi_config) begin
            isr_clr_c = isr_clr_c | (NUM_LEVELS'(1) << level_q);
            if (auto_rotate_mode) rot_d = LEVEL_W'(level_q + LEVEL_W'(1));
        end

        if (eoi_command) begin
            if (eoi_specific) begin
                isr_clr_c = isr_clr_c | (NUM_LEVELS'(1) << eoi_level);
                if (eoi_rotate) rot_d = LEVEL_W'(eoi_level + LEVEL_W'(1));
            end else if (ns_eoi_valid_c) begin
                isr_clr_c = isr_clr_c | (NUM_LEVELS'(1) << ns_eoi_level_c);
                if (eoi_rotate) rot_d = LEVEL_W'(ns_eoi_level_c + LEVEL_W'(1));
            end
        end

        // Set-priority is applied last so it overrides any EOI rotation in the same cycle.
        if (set_priority_command) rot_d = LEVEL_W'(set_priority_level + LEVEL_W'(1));

        // A bit being set this cycle survives a simultaneous EOI on it.
        isr_d = (isr_q & ~isr_clr_c) | isr_set_c;

        if (!interrupt_acknowledge_n) begin
            case (state_d)
                ST_ACK1: begin
                    if (!u8086_or_mcs80_config) begin
                        ode_d  = 1'b1;
                        data_d = MCS80_CALL_OPCODE;
                    end
                end
                ST_ACK2: begin
                    ode_d  = 1'b1;
                    data_d = u8086_or_mcs80_config ?
                             {interrupt_vector_address, level_q} :
                             {interrupt_vector_address[4:2], level_q, 2'b00};
                end
                ST_ACK3: begin
                    ode_d  = 1'b1;
                    data_d = call_address_high;
                end
                default: begin
                    ode_d  = 1'b0;
                    data_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inta_prev_q <= 1'b1;
            level_q     <= '0;
            isr_q       <= '0;
            rot_q       <= '0;
            cir_q       <= '0;
            int_q       <= 1'b0;
            data_q      <= '0;
            ode_q       <= 1'b0;
        end else begin
            inta_prev_q <= inta_prev_d;
            level_q     <= level_d;
            isr_q       <= isr_d;
            rot_q       <= rot_d;
            cir_q       <= cir_d;
            int_q       <= int_d;
            data_q      <= data_d;
            ode_q       <= ode_d;
        end
    end

    assign interrupt_to_cpu        = int_q;
    assign in_service_register     = isr_q;
    assign priority_rotate         = rot_q;
    assign clear_interrupt_request = cir_q;
    assign data_bus_out            = data_q;
    assign out_data_enable         = ode_q;

endmodule
